// File: rtl/obs_pkg.sv
// Shared constants and state encoding for the obstacle wave controller.
// Optional feature macro used by the controller: OBS_SPEEDUP_EN.
package obs_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAY      = 2'd1,
      PAUSE     = 2'd2,
      GAME_OVER = 2'd3
   } obs_state_t;

   localparam int MAX_X = 640;
   localparam int MAX_Y = 480;
   localparam int X_OFFSET = 32;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Spawn column: nine random bits shifted right by the offset, giving 32..543.
   function automatic logic [10:0] spawn_x(input logic [15:0] rnd);
      return {2'b00, rnd[8:0]} + 11'(X_OFFSET);
   endfunction

endpackage

// File: rtl/obs_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for spawn columns.
module obs_lfsr16
   import obs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] value
);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= LFSR_SEED;
      end else begin
         value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
      end
   end

endmodule

// File: rtl/obs_wave_ctrl.sv
// Obstacle wave controller: game FSM, obstacle slot spawning/motion, hits and score.
// Define OBS_SPEEDUP_EN to make fall speed grow with the score (1..4 px/frame).
module obs_wave_ctrl
   import obs_pkg::*;
#(
   parameter int NSLOT        = 4,
   parameter int SPAWN_FRAMES = 60,
   parameter int OBS_H        = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  frame_tick,
   input  logic [NSLOT-1:0]      hit,
   output logic [NSLOT-1:0]      slot_active,
   output logic [11*NSLOT-1:0]   slot_x,
   output logic [11*NSLOT-1:0]   slot_y,
   output logic [15:0]           score,
   output logic                  game_over,
   output logic [1:0]            state
);

   localparam int CW = $clog2(SPAWN_FRAMES + 1);
   localparam logic [CW-1:0] SPAWN_LAST = CW'(SPAWN_FRAMES - 1);

   obs_state_t        state_q;
   logic [CW-1:0]     spawn_cnt;
   logic [15:0]       lfsr;
   logic [NSLOT-1:0]  hit_ok;
   logic [NSLOT-1:0]  survivors;
   logic [NSLOT-1:0]  free_onehot;
   logic [NSLOT-1:0]  spawn_mask;
   logic              spawn_due;
   logic              bottom;
   logic [16:0]       score_sum;
   logic [15:0]       score_next;
   logic [10:0]       speed;

   assign state = state_q;

   obs_lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (lfsr)
   );

   // A hit slot is removed before bottom detection, so a same-cycle hit wins.
   // The free slot is taken from the current occupancy, so a slot freed this
   // cycle cannot be refilled until the next one.
   always_comb begin
      hit_ok      = hit & slot_active;
      survivors   = slot_active & ~hit_ok;
      free_onehot = ~slot_active & (slot_active + NSLOT'(1));
      spawn_due   = frame_tick && (spawn_cnt == SPAWN_LAST);
      spawn_mask  = spawn_due ? free_onehot : '0;
      bottom      = 1'b0;
      score_sum   = {1'b0, score};
      for (int i = 0; i < NSLOT; i++) begin
         if (survivors[i] && (({1'b0, slot_y[11*i +: 11]} + 12'(OBS_H)) >= 12'(MAX_Y))) begin
            bottom = 1'b1;
         end
         score_sum = score_sum + 17'(hit_ok[i]);
      end
      score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

`ifdef OBS_SPEEDUP_EN
   // One extra pixel per frame for every eight kills, capped at four.
   always_comb begin
      if (score >= 16'd24) begin
         speed = 11'd4;
      end else begin
         speed = 11'd1 + 11'(score[4:3]);
      end
   end
`else
   assign speed = 11'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         slot_active <= '0;
         slot_x      <= '0;
         slot_y      <= '0;
         score       <= '0;
         game_over   <= 1'b0;
         spawn_cnt   <= '0;
      end else begin
         case (state_q)
            IDLE, GAME_OVER: begin
               if (start) begin
                  state_q     <= PLAY;
                  slot_active <= '0;
                  slot_x      <= '0;
                  slot_y      <= '0;
                  score       <= '0;
                  game_over   <= 1'b0;
                  spawn_cnt   <= '0;
               end
            end
            PAUSE: begin
               if (pause) begin
                  state_q <= PLAY;
               end
            end
            PLAY: begin
               score <= score_next;
               if (bottom) begin
                  state_q     <= GAME_OVER;
                  game_over   <= 1'b1;
                  slot_active <= '0;
               end else begin
                  slot_active <= survivors | spawn_mask;
                  if (frame_tick) begin
                     for (int i = 0; i < NSLOT; i++) begin
                        if (spawn_mask[i]) begin
                           slot_x[11*i +: 11] <= spawn_x(lfsr);
                           slot_y[11*i +: 11] <= '0;
                        end else if (survivors[i]) begin
                           slot_y[11*i +: 11] <= slot_y[11*i +: 11] + speed;
                        end
                     end
                     // With every slot busy the counter parks at its last value.
                     if (!spawn_due) begin
                        spawn_cnt <= spawn_cnt + CW'(1);
                     end else if (|free_onehot) begin
                        spawn_cnt <= '0;
                     end
                  end
                  if (pause) begin
                     state_q <= PAUSE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obs_wave_ctrl.sv
// Self-checking bench for obs_wave_ctrl: directed scenarios plus a randomized run
// compared against a behavioural game model.
module tb_obs_wave_ctrl;

   localparam int NSLOT = 4;
   localparam int SF    = 60;
   localparam int OBS_H = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        pause;
   logic        frame_tick;
   logic [3:0]  hit;
   logic [3:0]  slot_active;
   logic [43:0] slot_x;
   logic [43:0] slot_y;
   logic [15:0] score;
   logic        game_over;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   obs_wave_ctrl #(.NSLOT(NSLOT), .SPAWN_FRAMES(SF), .OBS_H(OBS_H)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .frame_tick  (frame_tick),
      .hit         (hit),
      .slot_active (slot_active),
      .slot_x      (slot_x),
      .slot_y      (slot_y),
      .score       (score),
      .game_over   (game_over),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Behavioural game model: integer arrays stepped once per rising edge.
   int m_state, m_score, m_cnt, m_lfsr, m_go;
   int m_act [NSLOT];
   int m_x   [NSLOT];
   int m_y   [NSLOT];
   int m_free, m_kills, m_bottom, m_speed, m_fb;

   always @(posedge clk) begin
      if (reset) begin
         m_state = 0; m_score = 0; m_cnt = 0; m_go = 0; m_lfsr = 'hACE1;
         for (int i = 0; i < NSLOT; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      end else begin
         if (m_state == 0 || m_state == 3) begin
            if (start) begin
               m_state = 1; m_score = 0; m_cnt = 0; m_go = 0;
               for (int i = 0; i < NSLOT; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
            end
         end else if (m_state == 2) begin
            if (pause) m_state = 1;
         end else begin
            m_free = -1;
            for (int i = NSLOT - 1; i >= 0; i--) if (m_act[i] == 0) m_free = i;
`ifdef OBS_SPEEDUP_EN
            m_speed = 1 + ((m_score / 8 < 3) ? m_score / 8 : 3);
`else
            m_speed = 1;
`endif
            m_kills = 0; m_bottom = 0;
            for (int i = 0; i < NSLOT; i++) begin
               if (m_act[i] != 0 && hit[i]) begin
                  m_act[i] = 0; m_kills++;
               end else if (m_act[i] != 0 && m_y[i] + OBS_H >= 480) begin
                  m_bottom = 1;
               end
            end
            m_score = (m_score + m_kills > 65535) ? 65535 : m_score + m_kills;
            if (m_bottom != 0) begin
               m_state = 3; m_go = 1;
               for (int i = 0; i < NSLOT; i++) m_act[i] = 0;
            end else begin
               if (frame_tick) begin
                  for (int i = 0; i < NSLOT; i++) if (m_act[i] != 0) m_y[i] += m_speed;
                  if (m_cnt == SF - 1) begin
                     if (m_free >= 0) begin
                        m_act[m_free] = 1; m_x[m_free] = (m_lfsr & 'h1FF) + 32;
                        m_y[m_free] = 0; m_cnt = 0;
                     end
                  end else begin
                     m_cnt++;
                  end
               end
               if (pause) m_state = 2;
            end
         end
         m_fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
         m_lfsr = ((m_lfsr << 1) | m_fb) & 'hFFFF;
      end
   end

   function automatic int ys(input int i);
      return int'(slot_y[11*i +: 11]);
   endfunction

   function automatic int xs(input int i);
      return int'(slot_x[11*i +: 11]);
   endfunction

   task automatic drive_cycle(input logic ft, input logic [3:0] h, input logic st, input logic pa);
      frame_tick = ft; hit = h; start = st; pause = pa;
      @(posedge clk); #1;
      frame_tick = 1'b0; hit = 4'b0; start = 1'b0; pause = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; pause = 1'b1; frame_tick = 1'b1; hit = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; hit = 4'h0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
      checks++; if (slot_active !== 4'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0000", slot_active); end
      checks++; if (score !== 16'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_game_over: got %b expected 0", game_over); end
      checks++; if (slot_x !== 44'd0 || slot_y !== 44'd0) begin errors++; $display("[TB] FAIL reset_xy: got x=%h y=%h expected 0", slot_x, slot_y); end
   endtask

   task automatic test_spawn();
      drive_cycle(1'b0, 4'b0, 1'b1, 1'b0);
      checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
      repeat (SF) drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (slot_active !== 4'b0001) begin errors++; $display("[TB] FAIL spawn1_active: got %b expected 0001", slot_active); end
      checks++; if (ys(0) != 0) begin errors++; $display("[TB] FAIL spawn1_y0: got %0d expected 0", ys(0)); end
      checks++; if (xs(0) != m_x[0] || xs(0) < 32 || xs(0) > 543) begin errors++; $display("[TB] FAIL spawn1_x0: got %0d expected %0d", xs(0), m_x[0]); end
      repeat (SF) drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (slot_active !== 4'b0011) begin errors++; $display("[TB] FAIL spawn2_active: got %b expected 0011", slot_active); end
      checks++; if (ys(0) != 60 || ys(1) != 0) begin errors++; $display("[TB] FAIL spawn2_y: got y0=%0d y1=%0d expected 60 0", ys(0), ys(1)); end
   endtask

   task automatic test_hits();
      drive_cycle(1'b0, 4'b0011, 1'b0, 1'b0);
      checks++; if (slot_active !== 4'b0000) begin errors++; $display("[TB] FAIL hit_active: got %b expected 0000", slot_active); end
      checks++; if (score !== 16'd2) begin errors++; $display("[TB] FAIL hit_score: got %0d expected 2", score); end
      drive_cycle(1'b0, 4'b0100, 1'b0, 1'b0);
      checks++; if (score !== 16'd2) begin errors++; $display("[TB] FAIL hit_inactive_score: got %0d expected 2", score); end
   endtask

   task automatic test_bottom();
      int n = 0;
      while (game_over !== 1'b1 && n < 3000) begin
         drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
         n++;
      end
      checks++; if (game_over !== 1'b1) begin errors++; $display("[TB] FAIL bottom_timeout: got game_over=%b expected 1", game_over); end
      checks++; if (state !== 2'd3 || slot_active !== 4'b0) begin errors++; $display("[TB] FAIL bottom_state: got state=%0d active=%b expected 3 0000", state, slot_active); end
      checks++; if (ys(0) != 464) begin errors++; $display("[TB] FAIL bottom_y0: got %0d expected 464", ys(0)); end
      checks++; if (score !== 16'd2) begin errors++; $display("[TB] FAIL bottom_score_kept: got %0d expected 2", score); end
      drive_cycle(1'b0, 4'b0, 1'b1, 1'b0);
      checks++; if (state !== 2'd1 || score !== 16'd0 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL restart: got state=%0d score=%0d go=%b expected 1 0 0", state, score, game_over); end
   endtask

   task automatic test_conflict();
      repeat (SF + 463) drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (ys(0) != 463 || slot_active !== 4'b1111) begin errors++; $display("[TB] FAIL conflict_setup: got y0=%0d active=%b expected 463 1111", ys(0), slot_active); end
      drive_cycle(1'b1, 4'b0001, 1'b0, 1'b0);
      checks++; if (score !== 16'd1 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL conflict_hit: got score=%0d go=%b expected 1 0", score, game_over); end
      checks++; if (slot_active !== 4'b1110) begin errors++; $display("[TB] FAIL conflict_no_respawn: got %b expected 1110", slot_active); end
      drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (slot_active !== 4'b1111 || ys(0) != 0 || game_over !== 1'b0) begin errors++; $display("[TB] FAIL conflict_respawn: got active=%b y0=%0d go=%b expected 1111 0 0", slot_active, ys(0), game_over); end
   endtask

   task automatic test_pause();
      reset = 1'b1; pause = 1'b1; frame_tick = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; pause = 1'b0; frame_tick = 1'b0;
      checks++; if (state !== 2'd0 || score !== 16'd0 || slot_active !== 4'b0) begin errors++; $display("[TB] FAIL midgame_reset: got state=%0d score=%0d active=%b expected 0 0 0000", state, score, slot_active); end
      drive_cycle(1'b0, 4'b0, 1'b1, 1'b0);
      repeat (SF + 10) drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 4'b0, 1'b0, 1'b1);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL pause_state: got %0d expected 2", state); end
      repeat (100) drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 4'b0001, 1'b0, 1'b0);
      checks++; if (ys(0) != 10 || slot_active !== 4'b0001 || score !== 16'd0) begin errors++; $display("[TB] FAIL pause_frozen: got y0=%0d active=%b score=%0d expected 10 0001 0", ys(0), slot_active, score); end
      drive_cycle(1'b0, 4'b0, 1'b0, 1'b1);
      drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (state !== 2'd1 || ys(0) != 11) begin errors++; $display("[TB] FAIL pause_resume: got state=%0d y0=%0d expected 1 11", state, ys(0)); end
      drive_cycle(1'b0, 4'b0, 1'b0, 1'b1);
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      checks++; if (state !== 2'd0 || slot_active !== 4'b0) begin errors++; $display("[TB] FAIL pause_reset: got state=%0d active=%b expected 0 0000", state, slot_active); end
   endtask

`ifdef OBS_SPEEDUP_EN
   task automatic test_speedup();
      int n = 0;
      drive_cycle(1'b0, 4'b0, 1'b1, 1'b0);
      while (score < 16'd8 && n < 5000) begin drive_cycle(1'b1, slot_active, 1'b0, 1'b0); n++; end
      while (slot_active == 4'b0 && n < 5000) begin drive_cycle(1'b1, 4'b0, 1'b0, 1'b0); n++; end
      drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (score !== 16'd8 || ys(0) != 2) begin errors++; $display("[TB] FAIL speed2: got score=%0d y0=%0d expected 8 2", score, ys(0)); end
      while (score < 16'd24 && n < 5000) begin drive_cycle(1'b1, slot_active, 1'b0, 1'b0); n++; end
      while (slot_active == 4'b0 && n < 5000) begin drive_cycle(1'b1, 4'b0, 1'b0, 1'b0); n++; end
      drive_cycle(1'b1, 4'b0, 1'b0, 1'b0);
      checks++; if (score !== 16'd24 || ys(0) != 4) begin errors++; $display("[TB] FAIL speed4: got score=%0d y0=%0d expected 24 4", score, ys(0)); end
   endtask
`endif

   task automatic test_random();
      logic [3:0] ea;
      drive_cycle(1'b0, 4'b0, 1'b1, 1'b0);
      for (int c = 0; c < 4000 && errors < 20; c++) begin
         drive_cycle(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0,
                     1'($urandom_range(0, 40) == 0),
                     1'($urandom_range(0, 150) == 0));
         for (int i = 0; i < NSLOT; i++) ea[i] = (m_act[i] != 0);
         checks++; if (state !== 2'(m_state) || game_over !== 1'(m_go)) begin errors++; $display("[TB] FAIL rand_state c=%0d: got %0d/%b expected %0d/%0d", c, state, game_over, m_state, m_go); end
         checks++; if (slot_active !== ea || score !== 16'(m_score)) begin errors++; $display("[TB] FAIL rand_slots c=%0d: got %b/%0d expected %b/%0d", c, slot_active, score, ea, m_score); end
         for (int i = 0; i < NSLOT; i++) begin
            checks++; if (xs(i) != m_x[i] || ys(i) != m_y[i]) begin errors++; $display("[TB] FAIL rand_xy c=%0d slot=%0d: got %0d,%0d expected %0d,%0d", c, i, xs(i), ys(i), m_x[i], m_y[i]); end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; hit = 4'b0;
      test_reset();
      test_spawn();
      test_hits();
      test_bottom();
      test_conflict();
      test_pause();
`ifdef OBS_SPEEDUP_EN
      test_speedup();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
